// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: serial bit-pattern transmitter.
//
// Loads a parallel pattern word and shifts it out MSB-first, one bit per clock.
// The pattern can be sent (rep_count + 1) times, with 'gap' idle cycles between
// repetitions. All outputs are registered.
//
// Ports:
//   clk        clock, all logic on rising edge
//   rst        synchronous, active-high reset (priority over abort and start)
//   start      begin a transmission; sampled only while idle
//   abort      cancel the transmission in progress
//   pattern    bits to send; active field is pattern[length-1:0]
//   length     bits per repetition, valid range 1..WIDTH
//   rep_count  extra repetitions; total sends = rep_count + 1
//   gap        idle cycles inserted between repetitions
//   data_out   serial bit
//   valid      data_out carries a pattern bit this cycle
//   busy       transmission in progress
//   done       one-cycle pulse after the final bit
//   err        one-cycle pulse when start is rejected
//
// The repeat-count port is named rep_count because 'repeat' is a reserved word.

module serial_pattern_tx #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 4,
    parameter int unsigned REP_W = 4,
    parameter int unsigned GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] length,
    input  logic [REP_W-1:0] rep_count,
    input  logic [GAP_W-1:0] gap,
    output logic             data_out,
    output logic             valid,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

    localparam logic [LEN_W-1:0] MaxLen = LEN_W'(WIDTH);
    localparam logic [LEN_W-1:0] LenOne = LEN_W'(1);
    localparam logic [REP_W-1:0] RepOne = REP_W'(1);
    localparam logic [GAP_W-1:0] GapOne = GAP_W'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   pat_q, pat_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [REP_W-1:0]   rep_q, rep_d;     // repetitions still to come
    logic [GAP_W-1:0]   gap_q, gap_d;     // captured gap length
    logic [LEN_W-1:0]   idx_q, idx_d;     // index of the bit currently on data_out
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;   // remaining gap cycles minus one
    logic               data_q, data_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    // Bit select via shift keeps the index width independent of WIDTH.
    function automatic logic bit_at(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] i);
        logic [WIDTH-1:0] s;
        s = p >> i;
        return s[0];
    endfunction

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        rep_d   = rep_q;
        gap_d   = gap_q;
        idx_d   = idx_q;
        gcnt_d  = gcnt_q;
        data_d  = 1'b0;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    // abort alongside start cancels the request, so it is rejected
                    if (abort || (length == '0) || (length > MaxLen)) begin
                        err_d = 1'b1;
                    end else begin
                        pat_d   = pattern;
                        len_d   = length;
                        rep_d   = rep_count;
                        gap_d   = gap;
                        idx_d   = length - LenOne;
                        data_d  = bit_at(pattern, length - LenOne);
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        state_d = StSend;
                    end
                end
            end

            StSend: begin
                if (abort) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    rep_d   = '0;
                    gcnt_d  = '0;
                end else if (idx_q != '0) begin
                    idx_d   = idx_q - LenOne;
                    data_d  = bit_at(pat_q, idx_q - LenOne);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end else if (rep_q != '0) begin
                    rep_d  = rep_q - RepOne;
                    busy_d = 1'b1;
                    if (gap_q == '0) begin
                        idx_d   = len_q - LenOne;
                        data_d  = bit_at(pat_q, len_q - LenOne);
                        valid_d = 1'b1;
                    end else begin
                        gcnt_d  = gap_q - GapOne;
                        state_d = StGap;
                    end
                end else begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end

            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                    idx_d   = '0;
                    rep_d   = '0;
                    gcnt_d  = '0;
                end else begin
                    busy_d = 1'b1;
                    if (gcnt_q == '0) begin
                        idx_d   = len_q - LenOne;
                        data_d  = bit_at(pat_q, len_q - LenOne);
                        valid_d = 1'b1;
                        state_d = StSend;
                    end else begin
                        gcnt_d = gcnt_q - GapOne;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            pat_q   <= '0;
            len_q   <= '0;
            rep_q   <= '0;
            gap_q   <= '0;
            idx_q   <= '0;
            gcnt_q  <= '0;
            data_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            gap_q   <= gap_d;
            idx_q   <= idx_d;
            gcnt_q  <= gcnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data_out = data_q;
    assign valid    = valid_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Testbench for serial_pattern_tx. Expected output vectors
// {valid, data_out, busy, done, err} are queued when a transmission is started
// and popped one per clock as the DUT produces them.

module tb_serial_pattern_tx;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic [7:0] pattern;
    logic [3:0] length, rep_count;
    logic [2:0] gap;
    logic       data_out, valid, busy, done, err;

    int passed = 0;
    int total  = 0;
    logic [4:0] exp_q[$];
    logic [4:0] det_sr;

    serial_pattern_tx #(
        .WIDTH(8),
        .LEN_W(4),
        .REP_W(4),
        .GAP_W(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .pattern  (pattern),
        .length   (length),
        .rep_count(rep_count),
        .gap      (gap),
        .data_out (data_out),
        .valid    (valid),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Last five valid bits, as seen by a downstream 10101 detector.
    always @(posedge clk) begin
        if (rst) det_sr <= 5'b0;
        else if (valid) det_sr <= {det_sr[3:0], data_out};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic step_chk(input string tag);
        logic [4:0] e;
        step();
        e = 5'b0;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk(tag, {27'b0, valid, data_out, busy, done, err}, {27'b0, e});
    endtask

    task automatic run_n(input string tag, input int n);
        for (int i = 0; i < n; i++) step_chk(tag);
    endtask

    task automatic run_all(input string tag);
        while (exp_q.size() > 0) step_chk(tag);
        step_chk({tag, "_idle"});
    endtask

    function automatic void push_send(input logic [7:0] p, input int len, input int rep,
                                      input int g);
        for (int r = 0; r <= rep; r++) begin
            for (int b = len - 1; b >= 0; b--) exp_q.push_back({1'b1, p[b], 1'b1, 2'b00});
            if (r < rep) for (int k = 0; k < g; k++) exp_q.push_back(5'b00100);
        end
        exp_q.push_back(5'b00010);
    endfunction

    task automatic send(input string tag, input logic [7:0] p, input logic [3:0] l,
                        input logic [3:0] r, input logic [2:0] g);
        pattern   = p;
        length    = l;
        rep_count = r;
        gap       = g;
        start     = 1'b1;
        push_send(p, int'(l), int'(r), int'(g));
        step_chk(tag);
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        pattern = '0; length = '0; rep_count = '0; gap = '0;
        step();
        step();
        chk("reset_outputs", {27'b0, valid, data_out, busy, done, err}, 32'd0);
        rst = 1'b0;
        step_chk("idle_after_reset");

        // Single 10101 send, then detector sees the pattern
        send("single", 8'b0001_0101, 4'd5, 4'd0, 3'd0);
        run_all("single");
        chk("detector_10101", {27'b0, det_sr}, 32'b10101);

        send("back_to_back", 8'b101, 4'd3, 4'd2, 3'd0);
        run_all("back_to_back");

        send("gapped", 8'b11, 4'd2, 4'd1, 3'd3);
        run_all("gapped");

        // Rejected starts
        pattern = 8'hFF; length = 4'd0; start = 1'b1;
        exp_q.push_back(5'b00001);
        step_chk("reject_len0");
        start = 1'b0;
        step_chk("reject_len0_clear");
        length = 4'd9; start = 1'b1;
        exp_q.push_back(5'b00001);
        step_chk("reject_len9");
        start = 1'b0;
        step_chk("reject_len9_clear");

        // start and new inputs while busy are ignored
        send("busy_start", 8'hC3, 4'd8, 4'd0, 3'd0);
        run_n("busy_start", 2);
        start = 1'b1; pattern = 8'h00; length = 4'd4; rep_count = 4'd3;
        run_n("busy_start", 3);
        start = 1'b0;
        run_all("busy_start");

        // Abort on the 3rd bit
        send("abort", 8'hFF, 4'd8, 4'd0, 3'd0);
        run_n("abort", 2);
        abort = 1'b1;
        exp_q.delete();
        step_chk("abort_response");
        abort = 1'b0;
        step_chk("abort_no_done");

        // Reset on the 3rd bit
        send("rst_mid", 8'hFF, 4'd8, 4'd0, 3'd0);
        run_n("rst_mid", 2);
        rst = 1'b1;
        exp_q.delete();
        step_chk("rst_response");
        rst = 1'b0;
        step_chk("rst_no_done");

        // Maximum repeat count: 16 sends
        send("rep_max", 8'h01, 4'd1, 4'hF, 3'd0);
        run_all("rep_max");

        // Full width with start held through done: re-arm on the done cycle
        pattern = 8'hA5; length = 4'd8; rep_count = 4'd0; gap = 3'd0; start = 1'b1;
        push_send(8'hA5, 8, 0, 0);
        push_send(8'hA5, 8, 0, 0);
        run_n("rearm", 10);
        start = 1'b0;
        run_all("rearm");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
